timer_bank: RTL and testbench

TIMER_BANK -- requirements
Module: timer_bank

---
 rtl/timer_bank.sv | 138 +++++++++++++
 tb/tb_timer_bank.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_bank.sv
// rtl/timer_bank.sv - bank of bus-mapped compare timers with shared prescaler (optional: TIMER_BANK_PRESCALER_EN)
module timer_bank #(
  parameter int NUM_CH     = 4,
  parameter int WIDTH      = 32,
  parameter int PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_r_en,
  input  logic [31:0] bus_r_addr,
  output logic [31:0] bus_r_data,
  input  logic        bus_w_en,
  input  logic [31:0] bus_w_addr,
  input  logic [31:0] bus_w_data,
  output logic        irq
);

  localparam logic [31:0] PRESCALE_ADDR = 32'h0000_0080;

  logic        tick;
  logic [31:0] prescale_rd;

`ifdef TIMER_BANK_PRESCALER_EN
  logic [PRESCALE_W-1:0] prescale_q;
  logic [PRESCALE_W-1:0] pcnt_q;
  logic                  wr_prescale;

  assign wr_prescale = bus_w_en && (bus_w_addr == PRESCALE_ADDR);
  assign tick        = (pcnt_q == prescale_q);
  assign prescale_rd = 32'(prescale_q);

  // Prescale register and shared divider; a new divisor restarts the count
  always_ff @(posedge clk) begin
    if (rst) begin
      prescale_q <= '0;
      pcnt_q     <= '0;
    end else if (wr_prescale) begin
      prescale_q <= bus_w_data[PRESCALE_W-1:0];
      pcnt_q     <= '0;
    end else if (tick) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_q + PRESCALE_W'(1);
    end
  end
`else
  assign tick        = 1'b1;
  assign prescale_rd = '0;
`endif

  logic [WIDTH-1:0] count_v   [NUM_CH];
  logic [WIDTH-1:0] compare_v [NUM_CH];
  logic [3:0]       ctrl_v    [NUM_CH];
  logic [NUM_CH-1:0] match_v;
  logic [NUM_CH-1:0] irq_vec;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    localparam logic [31:0] BASE = 32'(ch * 16);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] compare_q;
    logic [3:0]       ctrl_q;
    logic             match_q;
    logic             wr_count;
    logic             wr_ctrl;
    logic             wr_compare;
    logic             wr_status;
    logic             hit;

    assign wr_count   = bus_w_en && (bus_w_addr == BASE);
    assign wr_ctrl    = bus_w_en && (bus_w_addr == BASE + 32'h4);
    assign wr_compare = bus_w_en && (bus_w_addr == BASE + 32'h8);
    assign wr_status  = bus_w_en && (bus_w_addr == BASE + 32'hC);
    assign hit        = tick && ctrl_q[0] && (count_q == compare_q);

    // Channel state: bus writes win over hardware updates, except MATCH set beats W1C
    always_ff @(posedge clk) begin
      if (rst) begin
        count_q   <= '0;
        compare_q <= '1;
        ctrl_q    <= '0;
        match_q   <= 1'b0;
      end else begin
        if (wr_count) begin
          count_q <= bus_w_data[WIDTH-1:0];
        end else if (tick && ctrl_q[0]) begin
          count_q <= (hit && ctrl_q[1]) ? '0 : count_q + WIDTH'(1);
        end

        if (wr_compare) begin
          compare_q <= bus_w_data[WIDTH-1:0];
        end

        if (wr_ctrl) begin
          ctrl_q <= bus_w_data[3:0];
        end else if (hit && ctrl_q[2]) begin
          ctrl_q[0] <= 1'b0;
        end

        if (hit) begin
          match_q <= 1'b1;
        end else if (wr_status && bus_w_data[0]) begin
          match_q <= 1'b0;
        end
      end
    end

    assign count_v[ch]   = count_q;
    assign compare_v[ch] = compare_q;
    assign ctrl_v[ch]    = ctrl_q;
    assign match_v[ch]   = match_q;
    assign irq_vec[ch]   = match_q & ctrl_q[3];
  end

  assign irq = |irq_vec;

  // Full-address read decode; anything unmapped reads zero
  always_comb begin
    bus_r_data = '0;
    if (bus_r_en) begin
      if (bus_r_addr == PRESCALE_ADDR) begin
        bus_r_data = prescale_rd;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus_r_addr == 32'(i * 16)) begin
          bus_r_data = 32'(count_v[i]);
        end else if (bus_r_addr == 32'(i * 16) + 32'h4) begin
          bus_r_data = 32'(ctrl_v[i]);
        end else if (bus_r_addr == 32'(i * 16) + 32'h8) begin
          bus_r_data = 32'(compare_v[i]);
        end else if (bus_r_addr == 32'(i * 16) + 32'hC) begin
          bus_r_data = 32'(match_v[i]);
        end
      end
    end
  end

endmodule

// File: tb/tb_timer_bank.sv
// tb/tb_timer_bank.sv - scoreboard bench for timer_bank (default and 8-bit instances)
module tb_timer_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_r_en;
  logic [31:0] bus_r_addr;
  logic [31:0] bus_r_data;
  logic [31:0] bus_r_data8;
  logic        bus_w_en;
  logic [31:0] bus_w_addr;
  logic [31:0] bus_w_data;
  logic        irq;
  logic        irq8;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  timer_bank dut (
    .clk(clk), .rst(rst),
    .bus_r_en(bus_r_en), .bus_r_addr(bus_r_addr), .bus_r_data(bus_r_data),
    .bus_w_en(bus_w_en), .bus_w_addr(bus_w_addr), .bus_w_data(bus_w_data),
    .irq(irq)
  );

  timer_bank #(.NUM_CH(4), .WIDTH(8), .PRESCALE_W(16)) dut8 (
    .clk(clk), .rst(rst),
    .bus_r_en(bus_r_en), .bus_r_addr(bus_r_addr), .bus_r_data(bus_r_data8),
    .bus_w_en(bus_w_en), .bus_w_addr(bus_w_addr), .bus_w_data(bus_w_data),
    .irq(irq8)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp,
                    input bit sel8 = 1'b0, input bit en = 1'b1);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
    bus_r_en   = en;
    bus_r_addr = addr;
    #1;
    e = sb_q.pop_front();
    check_val(e.tag, sel8 ? bus_r_data8 : bus_r_data, e.exp);
    bus_r_en = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus_w_en   = 1'b1;
    bus_w_addr = addr;
    bus_w_data = data;
    @(posedge clk);
    #1;
    bus_w_en = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    bus_r_en   = 1'b0;
    bus_r_addr = '0;
    bus_w_en   = 1'b0;
    bus_w_addr = '0;
    bus_w_data = '0;
    step(2);
    rst = 1'b0;

    rd("rst_count0", 32'h00, 32'h0);
    rd("rst_ctrl0", 32'h04, 32'h0);
    rd("rst_cmp0", 32'h08, 32'hFFFF_FFFF);
    rd("rst_stat0", 32'h0C, 32'h0);
    rd("rst_cmp3", 32'h38, 32'hFFFF_FFFF);
    rd("rst_prescale", 32'h80, 32'h0);
    check_val("rst_irq", 32'(irq), 32'h0);

    // free-running count past compare, no IRQ_EN
    wr(32'h08, 32'd5);
    wr(32'h04, 32'h1);
    rd("c0_start", 32'h00, 32'd0);
    step(5);
    rd("c0_at5", 32'h00, 32'd5);
    rd("c0_nomatch_yet", 32'h0C, 32'h0);
    step(1);
    rd("c0_at6", 32'h00, 32'd6);
    rd("c0_match", 32'h0C, 32'h1);
    check_val("c0_irq_masked", 32'(irq), 32'h0);
    rd("ren_low", 32'h00, 32'h0, 1'b0, 1'b0);
    wr(32'h04, 32'h0);
    wr(32'h0C, 32'h1);
    rd("c0_w1c", 32'h0C, 32'h0);

    // periodic channel with interrupt
    wr(32'h18, 32'd3);
    wr(32'h14, 32'hB);
    rd("c1_seq0", 32'h10, 32'd0);
    step(1);
    rd("c1_seq1", 32'h10, 32'd1);
    step(1);
    rd("c1_seq2", 32'h10, 32'd2);
    step(1);
    rd("c1_seq3", 32'h10, 32'd3);
    check_val("c1_irq_pre", 32'(irq), 32'h0);
    step(1);
    rd("c1_wrap", 32'h10, 32'd0);
    rd("c1_match", 32'h1C, 32'h1);
    check_val("c1_irq_set", 32'(irq), 32'h1);
    wr(32'h1C, 32'h1);
    check_val("c1_irq_clr", 32'(irq), 32'h0);
    rd("c1_after_clr", 32'h10, 32'd1);
    step(2);
    rd("c1_pre_race", 32'h10, 32'd3);
    wr(32'h1C, 32'h1);
    rd("c1_set_beats_w1c", 32'h1C, 32'h1);
    check_val("c1_irq_race", 32'(irq), 32'h1);
    rd("c1_race_wrap", 32'h10, 32'd0);
    wr(32'h14, 32'hFFFF_FFF0);
    rd("c1_ctrl_mask", 32'h14, 32'h0);
    wr(32'h1C, 32'h1);
    check_val("c1_irq_off", 32'(irq), 32'h0);

    // one-shot channel
    wr(32'h28, 32'd2);
    wr(32'h24, 32'h5);
    rd("c2_start", 32'h20, 32'd0);
    step(3);
    rd("c2_stop", 32'h20, 32'd3);
    rd("c2_ctrl", 32'h24, 32'h4);
    rd("c2_match", 32'h2C, 32'h1);
    step(2);
    rd("c2_held", 32'h20, 32'd3);
    wr(32'h20, 32'd0);
    wr(32'h24, 32'h5);
    step(2);
    rd("c2_pre_ovr", 32'h20, 32'd2);
    wr(32'h24, 32'h5);
    rd("c2_ctrl_ovr", 32'h24, 32'h5);
    rd("c2_cnt_ovr", 32'h20, 32'd3);
    step(1);
    rd("c2_still_en", 32'h20, 32'd4);
    wr(32'h24, 32'h0);

    // prescaler
    wr(32'h00, 32'd0);
`ifdef TIMER_BANK_PRESCALER_EN
    wr(32'h80, 32'd3);
    wr(32'h04, 32'h1);
    rd("ps_start", 32'h00, 32'd0);
    rd("ps_reg", 32'h80, 32'd3);
    step(2);
    rd("ps_hold", 32'h00, 32'd0);
    step(1);
    rd("ps_tick1", 32'h00, 32'd1);
    step(3);
    rd("ps_hold2", 32'h00, 32'd1);
    step(1);
    rd("ps_tick2", 32'h00, 32'd2);
    wr(32'h04, 32'h0);
    wr(32'h80, 32'd0);
`else
    wr(32'h80, 32'd3);
    rd("ps_reg_absent", 32'h80, 32'd0);
    wr(32'h04, 32'h1);
    rd("ps_start", 32'h00, 32'd0);
    step(1);
    rd("ps_every1", 32'h00, 32'd1);
    step(3);
    rd("ps_every4", 32'h00, 32'd4);
    wr(32'h04, 32'h0);
`endif

    // reset beats a same-cycle write
    bus_w_en   = 1'b1;
    bus_w_addr = 32'h08;
    bus_w_data = 32'd7;
    rst        = 1'b1;
    step(1);
    rst      = 1'b0;
    bus_w_en = 1'b0;
    rd("rstpri_cmp0", 32'h08, 32'hFFFF_FFFF);
    rd("rstpri_cnt2", 32'h20, 32'h0);
    rd("rstpri_stat2", 32'h2C, 32'h0);

    // 8-bit wrap and tick-cycle count write
    wr(32'h08, 32'h10);
    wr(32'h00, 32'hFF);
    wr(32'h04, 32'h1);
    rd("w8_ff", 32'h00, 32'hFF, 1'b1);
    step(1);
    rd("w8_wrap", 32'h00, 32'h00, 1'b1);
    rd("w8_nomatch", 32'h0C, 32'h0, 1'b1);
    wr(32'h00, 32'h20);
    rd("w8_wr_ovr", 32'h00, 32'h20, 1'b1);
    step(1);
    rd("w8_next", 32'h00, 32'h21, 1'b1);
    wr(32'h00, 32'h1AB);
    rd("w8_lowbits", 32'h00, 32'hAB, 1'b1);
    wr(32'h04, 32'h0);

    // unmapped and out-of-range channels
    rd("unmap_90", 32'h90, 32'h0);
    rd("ch5_count", 32'h50, 32'h0);
    wr(32'h90, 32'hDEAD_BEEF);
    wr(32'h50, 32'h55);
    wr(32'h54, 32'hF);
    wr(32'h58, 32'h0);
    wr(32'h5C, 32'h1);
    wr(32'h1000_0004, 32'h1);
    wr(32'h8000_0008, 32'h0);
    rd("unmap_ctrl0", 32'h04, 32'h0);
    rd("unmap_cmp0", 32'h08, 32'h10);
    rd("unmap_cmp1", 32'h18, 32'hFFFF_FFFF);
    rd("unmap_ctrl1", 32'h14, 32'h0);
    rd("unmap_cnt0", 32'h00, 32'h1AC);
    rd("unmap_cnt0_w8", 32'h00, 32'hAC, 1'b1);
    rd("unmap_prescale", 32'h80, 32'h0);
    rd("unmap_ch5_after", 32'h54, 32'h0);
    check_val("unmap_irq", 32'(irq), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
